// File: rtl/branch_compare_stage.sv
// -----------------------------------------------------------------------------
// branch_compare_stage
//
// Purpose:
//   Two-entry skid buffer that evaluates RV32I branch conditions. The branch
//   flags are computed once, when an entry is pushed, from the operands and
//   from the difference produced by an external DSP subtractor. The flags are
//   then held with the entry until the downstream stage pops it.
//
// Ports:
//   clk          - single clock, rising edge
//   rst_n        - asynchronous active-low reset
//   flush        - synchronous discard of all buffered entries (wins over push/pop)
//   in_valid     - upstream entry present
//   in_ready     - stage can accept an entry (count < 2, from registers only)
//   op_a, op_b   - rs1 / rs2 operands
//   diff         - op_a - op_b mod 2^32, from the external subtractor
//   funct3       - RV32I branch funct3
//   out_valid    - head entry present (count != 0)
//   out_ready    - downstream accepts the head entry
//   out_taken    - branch decision for the head entry
//   out_eq/lt/ltu- raw compare flags for the head entry
//   out_illegal  - head entry funct3 was 010 or 011
//   out_diff     - registered diff for the head entry
// -----------------------------------------------------------------------------
module branch_compare_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [31:0] diff,
  input  logic [2:0]  funct3,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_taken,
  output logic        out_eq,
  output logic        out_lt,
  output logic        out_ltu,
  output logic        out_illegal,
  output logic [31:0] out_diff
);

  typedef struct packed {
    logic        taken;
    logic        eq;
    logic        lt;
    logic        ltu;
    logic        illegal;
    logic [31:0] diff;
  } entry_t;

  // Branch flag evaluation from the shared subtractor result. When the sign
  // bits differ the subtraction may overflow, so the operand signs decide.
  function automatic entry_t compute_entry(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [31:0] d,
    input logic [2:0]  f
  );
    entry_t e;
    e.diff    = d;
    e.eq      = (d == 32'd0);
    e.lt      = (a[31] != b[31]) ? a[31] : d[31];
    e.ltu     = (a[31] != b[31]) ? b[31] : d[31];
    e.illegal = 1'b0;
    case (f)
      3'b000:  e.taken = e.eq;
      3'b001:  e.taken = ~e.eq;
      3'b100:  e.taken = e.lt;
      3'b101:  e.taken = ~e.lt;
      3'b110:  e.taken = e.ltu;
      3'b111:  e.taken = ~e.ltu;
      default: begin
        e.taken   = 1'b0;
        e.illegal = 1'b1;
      end
    endcase
    return e;
  endfunction

  logic [1:0] r_count;
  entry_t     r_slot0;   // head entry
  entry_t     r_slot1;   // entry behind the head

  logic [1:0] w_count_nxt;
  entry_t     w_slot0_nxt;
  entry_t     w_slot1_nxt;
  entry_t     w_new;
  logic       w_push;
  logic       w_pop;

  assign w_new  = compute_entry(op_a, op_b, diff, funct3);
  assign w_push = in_valid && in_ready;
  assign w_pop  = out_valid && out_ready;

  // Next-state for occupancy and storage slots; flush overrides any handshake.
  always_comb begin
    w_count_nxt = r_count;
    w_slot0_nxt = r_slot0;
    w_slot1_nxt = r_slot1;
    if (flush) begin
      w_count_nxt = 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) begin
            w_slot0_nxt = w_new;
          end else begin
            w_slot1_nxt = w_new;
          end
          w_count_nxt = r_count + 2'd1;
        end
        2'b01: begin
          w_slot0_nxt = r_slot1;
          w_count_nxt = r_count - 2'd1;
        end
        2'b11: begin
          // Push with pop only happens at count 1 (in_ready is low at 2),
          // so the new entry becomes the head directly.
          if (r_count == 2'd1) begin
            w_slot0_nxt = w_new;
          end else begin
            w_slot0_nxt = r_slot1;
            w_slot1_nxt = w_new;
          end
        end
        default: begin
          w_count_nxt = r_count;
        end
      endcase
    end
  end

  // State registers with asynchronous reset clearing all entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= 2'd0;
      r_slot0 <= '0;
      r_slot1 <= '0;
    end else begin
      r_count <= w_count_nxt;
      r_slot0 <= w_slot0_nxt;
      r_slot1 <= w_slot1_nxt;
    end
  end

  assign in_ready    = (r_count < 2'd2);
  assign out_valid   = (r_count != 2'd0);
  assign out_taken   = r_slot0.taken;
  assign out_eq      = r_slot0.eq;
  assign out_lt      = r_slot0.lt;
  assign out_ltu     = r_slot0.ltu;
  assign out_illegal = r_slot0.illegal;
  assign out_diff    = r_slot0.diff;

endmodule

// File: tb/tb_branch_compare_stage.sv
module tb_branch_compare_stage;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] diff;
  logic [2:0]  funct3;
  logic        out_valid;
  logic        out_ready;
  logic        out_taken;
  logic        out_eq;
  logic        out_lt;
  logic        out_ltu;
  logic        out_illegal;
  logic [31:0] out_diff;

  int tests;
  int fails;

  logic [36:0] sb_q[$];

  branch_compare_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .diff(diff), .funct3(funct3),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_taken(out_taken), .out_eq(out_eq), .out_lt(out_lt),
    .out_ltu(out_ltu), .out_illegal(out_illegal), .out_diff(out_diff)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {taken, eq, lt, ltu, illegal, diff} from plain comparisons.
  function automatic logic [36:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] f);
    logic eq, lt, ltu, t, ill;
    eq  = (a == b);
    lt  = ($signed(a) < $signed(b));
    ltu = (a < b);
    ill = 1'b0;
    case (f)
      3'b000:  t = eq;
      3'b001:  t = !eq;
      3'b100:  t = lt;
      3'b101:  t = !lt;
      3'b110:  t = ltu;
      3'b111:  t = !ltu;
      default: begin t = 1'b0; ill = 1'b1; end
    endcase
    return {t, eq, lt, ltu, ill, a - b};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] f);
    in_valid = v;
    op_a     = a;
    op_b     = b;
    diff     = a - b;
    funct3   = f;
  endtask

  // One clock: check handshake/head against the scoreboard, then advance it.
  task automatic tick();
    logic       m_push, m_pop;
    logic [36:0] exp_e;
    chk("out_valid", out_valid, (sb_q.size() != 0));
    chk("in_ready", in_ready, (sb_q.size() < 2));
    if (sb_q.size() != 0)
      chk("head", {out_taken, out_eq, out_lt, out_ltu, out_illegal, out_diff}, sb_q[0]);
    m_pop  = (sb_q.size() != 0) && out_ready;
    m_push = in_valid && (sb_q.size() < 2);
    exp_e  = model(op_a, op_b, funct3);
    @(posedge clk);
    #1;
    if (flush) begin
      sb_q.delete();
    end else begin
      if (m_pop)  void'(sb_q.pop_front());
      if (m_push) sb_q.push_back(exp_e);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 3'b000);
    @(posedge clk);
    #1;
    // Reset state
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_flags", {out_taken, out_eq, out_lt, out_ltu, out_illegal}, 5'd0);
    chk("rst_diff", out_diff, 32'd0);
    rst_n = 1'b1;

    // BEQ taken, pushed on the first edge after reset release
    out_ready = 1'b1;
    drive(1'b1, 32'd5, 32'd5, 3'b000);
    tick();
    drive(1'b0, 32'd0, 32'd0, 3'b000);
    chk("beq_valid", out_valid, 1'b1);
    chk("beq_taken", out_taken, 1'b1);
    chk("beq_eq", out_eq, 1'b1);
    tick();

    // Signed vs unsigned
    drive(1'b1, 32'hFFFF_FFFF, 32'd1, 3'b100);
    tick();
    chk("blt_taken", out_taken, 1'b1);
    drive(1'b1, 32'hFFFF_FFFF, 32'd1, 3'b110);
    tick();
    chk("bltu_taken", out_taken, 1'b0);
    chk("bltu_ltu", out_ltu, 1'b0);
    chk("bltu_diff", out_diff, 32'hFFFF_FFFE);
    drive(1'b0, 32'd0, 32'd0, 3'b000);
    tick();

    // Backpressure: three back-to-back pushes with out_ready low
    out_ready = 1'b0;
    drive(1'b1, 32'd10, 32'd20, 3'b100);
    tick();
    drive(1'b1, 32'h8000_0000, 32'd3, 3'b101);
    tick();
    drive(1'b1, 32'd7, 32'd7, 3'b001);
    tick();
    tick();
    chk("bp_full_ready", in_ready, 1'b0);
    out_ready = 1'b1;
    tick();
    chk("bp_after_pop_ready", in_ready, 1'b1);
    tick();
    drive(1'b0, 32'd0, 32'd0, 3'b000);
    tick();
    tick();

    // Streaming at count 1: one in, one out per cycle
    out_ready = 1'b0;
    drive(1'b1, 32'd1, 32'd2, 3'b110);
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, $urandom, $urandom, 3'($urandom_range(0, 7)));
      tick();
      chk("stream_count1", {out_valid, in_ready}, 2'b11);
    end
    drive(1'b0, 32'd0, 32'd0, 3'b000);
    tick();
    tick();

    // Flush with simultaneous push and pop at count 2
    out_ready = 1'b0;
    drive(1'b1, 32'd100, 32'd1, 3'b111);
    tick();
    drive(1'b1, 32'd1, 32'd100, 3'b111);
    tick();
    out_ready = 1'b1;
    flush = 1'b1;
    drive(1'b1, 32'd42, 32'd42, 3'b000);
    tick();
    flush = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 3'b000);
    chk("flush_valid", out_valid, 1'b0);
    chk("flush_ready", in_ready, 1'b1);
    tick();
    tick();

    // Illegal funct3 then asynchronous reset mid-stream
    out_ready = 1'b0;
    drive(1'b1, 32'd9, 32'd4, 3'b010);
    tick();
    drive(1'b1, 32'd9, 32'd4, 3'b000);
    tick();
    chk("ill_illegal", out_illegal, 1'b1);
    chk("ill_taken", out_taken, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 1'b0);
    chk("arst_ready", in_ready, 1'b1);
    chk("arst_diff", out_diff, 32'd0);
    sb_q.delete();
    @(posedge clk);
    #1;
    chk("arst_hold_valid", out_valid, 1'b0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 32'd3, 32'd8, 3'b101);
    tick();
    drive(1'b0, 32'd0, 32'd0, 3'b000);
    chk("post_rst_push", out_valid, 1'b1);
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/branch_compare_stage.md
BRANCH_COMPARE_STAGE -- requirements
Module: branch_compare_stage

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 flush  input  1  synchronous discard of all buffered entries.
REQ-004 in_valid  input  1  upstream entry present.
REQ-005 in_ready  output  1  stage can accept an entry this cycle.
REQ-006 op_a  input  32  rs1 operand, same value driven to the DSP subtractor input1.
REQ-007 op_b  input  32  rs2 operand, same value driven to the DSP subtractor input2.
REQ-008 diff  input  32  subtractor output, op_a - op_b mod 2^32, combinational in the same cycle.
REQ-009 funct3  input  3  RV32I branch funct3.
REQ-010 out_valid  output  1  head entry present.
REQ-011 out_ready  input  1  downstream accepts head entry.
REQ-012 out_taken  output  1  branch condition result for head entry.
REQ-013 out_eq / out_lt / out_ltu  output  1 each  raw compare flags for head entry.
REQ-014 out_illegal  output  1  head entry funct3 is 010 or 011.
REQ-015 out_diff  output  32  registered diff for head entry.

Function
REQ-016 The stage SHALL be a 2-entry FIFO (skid buffer) with an occupancy count of 0..2.
REQ-017 The push SHALL occur when in_valid && in_ready; the pop SHALL occur when out_valid && out_ready.
REQ-018 in_ready SHALL equal (count < 2), decoded from registers only, with no combinational path from out_ready.
REQ-019 out_valid SHALL equal (count != 0); output fields SHALL come from the head entry.
REQ-020 Latency SHALL be 1 cycle: an entry pushed at edge N is presented at the head no earlier than after edge N, and at count 0 it is visible in the cycle after the push.
REQ-021 Flags SHALL be computed at push and stored; eq = (diff == 0).
REQ-022 lt SHALL be computed as (op_a[31] != op_b[31]) ? op_a[31] : diff[31].
REQ-023 ltu SHALL be computed as (op_a[31] != op_b[31]) ? op_b[31] : diff[31].
REQ-024 taken SHALL decode from funct3 as: 000 eq; 001 !eq; 100 lt; 101 !lt; 110 ltu; 111 !ltu; 010/011 give taken=0 and illegal=1.
REQ-025 On a simultaneous push and pop, count SHALL be unchanged, and FIFO order SHALL be preserved (the entry behind the head moves up).
REQ-026 When count = 2, in_ready SHALL be 0 even if out_ready = 1 in that cycle.
REQ-027 A pop at count 0 SHALL be impossible; out_ready alone SHALL have no effect.
REQ-028 flush SHALL set count to 0 at the next edge; a push or pop in the same cycle SHALL be discarded (flush wins).
REQ-029 Stored entries SHALL NOT change while they wait (hold under out_ready = 0).

Reset
REQ-030 While rst_n = 0, the stage SHALL hold count = 0, out_valid = 0, in_ready = 1, out_taken/out_eq/out_lt/out_ltu/out_illegal = 0, and out_diff = 0.
REQ-031 Reset asserted mid-operation SHALL drop all entries immediately (asynchronous), with no output glitch to out_valid = 1.
REQ-032 After rst_n deasserts, the first push SHALL be accepted on the first rising edge.

Verification
REQ-033 BEQ: op_a = 5, op_b = 5, diff = 0, funct3 = 000, out_ready = 1 -> next cycle out_valid = 1, out_taken = 1, out_eq = 1.
REQ-034 Signed vs unsigned: op_a = 0xFFFFFFFF, op_b = 1, diff = 0xFFFFFFFE -> BLT (100) taken = 1; BLTU (110) taken = 0 with out_ltu = 0.
REQ-035 Backpressure: hold out_ready = 0 and push 3 entries back-to-back -> first two accepted, in_ready = 0 on the third, and the third is accepted only after a pop; order is preserved.
REQ-036 Simultaneous push and pop at count = 1 for 10 cycles with out_ready = 1 -> count stays 1 and the outputs stream in order at one per cycle.
REQ-037 Flush plus push at count = 2 -> next cycle count = 0, out_valid = 0, and the pushed entry never appears.
REQ-038 Illegal funct3 = 010, then rst_n pulsed low mid-stream -> first out_illegal = 1 with out_taken = 0; then out_valid drops to 0 asynchronously and in_ready = 1.
